ray_gen: RTL and testbench
==========================

Name: ray_gen

Overview:
- Upstream neighbour of the object-intersection stage.
- Scans the render window pixel by pixel and emits one primary-ray direction per pixel as three IEEE-754 single-precision floats on an AXI-stream style handshake.
- Each ray carries its hcount/vcount tag and the object-select mask.
- Converts signed integer offsets to float internally. No float IP, one output register stage.

Parameters:
- H_ACTIVE, 320, pixels per row; rays generated for hcount 0..H_ACTIVE-1
- V_ACTIVE, 180, rows per frame; rays generated for vcount 0..V_ACTIVE-1
- H_CENTER, 160, hcount of the optical axis
- V_CENTER, 90, vcount of the optical axis
- FOCAL, 200, focal distance in pixels (positive integer < 2048)
- SIZE, 32, float width (fixed single precision)

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame when idle
- select_objs_in  in  2  object mask; sampled on accepted start
- ray_axis_tdata  out  3*SIZE  packed [2:0]: [2]=dx, [1]=dy, [0]=dz, floats
- ray_axis_tvalid  out  1  beat valid
- ray_axis_tready  in  1  downstream ready
- hcount_axis_tdata  out  11  pixel column of current beat
- vcount_axis_tdata  out  10  pixel row of current beat
- select_objs  out  2  registered mask, constant for the whole frame
- busy  out  1  high from accepted start until last beat accepted
- frame_done  out  1  one-cycle pulse after last beat accepted

Behaviour:
- Interface: one clock aclk; reset aresetn is asynchronous and active-low.
- Reset values (asynchronous): state IDLE; tvalid=0; tdata=0; hcount/vcount outputs=0; select_objs=0; busy=0; frame_done=0; internal next-pixel counters=0.
- States:
  - IDLE: start=1 → RUN; latch select_objs; clear counters; busy=1.
  - RUN: emit beats; after last beat's handshake → IDLE; frame_done=1 for that one cycle; busy=0 same edge.
  - start during RUN is ignored.
- Counters point to the next pixel to load. The output register loads when state==RUN, pixels remain, and (tvalid==0 or tready==1).
- On load, tdata and h/v outputs take the counter pixel's values and tvalid=1. Counters then advance:
  - hcount increments first.
  - At H_ACTIVE-1, hcount wraps to 0 and vcount increments.
  - After (H_ACTIVE-1, V_ACTIVE-1), no further loads happen.
- If a handshake occurs with nothing left to load, tvalid drops to 0 the next cycle.
- Backpressure: while tvalid=1 and tready=0, tdata, hcount and vcount hold stable.
- Throughput: 1 beat/cycle under continuous tready.
- Latency: first tvalid is asserted the cycle after start is sampled.
- Arithmetic:
  - dx = hcount - H_CENTER; dy = V_CENTER - vcount; dz = -FOCAL.
  - Computed as 13-bit signed integers and converted exactly to float32 (all magnitudes < 2^24, so no rounding).
  - Conversion: sign = MSB; magnitude via priority encoder; exponent = 127 + msb_index; mantissa = magnitude << (23 - msb_index) with the hidden bit dropped.
  - Zero converts to 32'h00000000, never -0.
- Frame totals: exactly H_ACTIVE*V_ACTIVE beats per frame, in raster order, no duplicates or gaps under any tready pattern.
- frame_done and start in the same cycle: frame_done pulses and start is ignored (state still RUN at that edge). start is accepted on the following cycle or later.
- Reset mid-frame aborts immediately. No frame_done. The next start begins at pixel (0,0).

Test Plan:
- Reset, start, tready=1 constantly → first beat hcount=0, vcount=0 with tdata {C3200000, 42B40000, C3480000}. tvalid is asserted one cycle after start. Beats are contiguous.
- Same run → beat (160,90) has dx=dy=32'h00000000. Last beat (319,179) is {431F0000, C2B20000, C3480000}. frame_done pulses once. Total beat count is 57600.
- Random tready (50%) → tdata/hcount/vcount are stable while stalled. The beat sequence is identical to the continuous run, and no beat is lost or duplicated.
- start pulsed mid-frame, and select_objs_in changed mid-frame → ignored. select_objs keeps the value latched at frame start (e.g. 2'b11).
- aresetn asserted at beat ~1000 with tvalid high → tvalid=0 and busy=0 immediately (asynchronous). A new start restarts at (0,0) and frame_done appears only at the end of the new frame.
- Small parameters H_ACTIVE=3, V_ACTIVE=2, H_CENTER=1, V_CENTER=1, FOCAL=1 → 6 beats in order (0,0)(1,0)(2,0)(0,1)(1,1)(2,1). The dx sequence is -1,0,1 → BF800000, 00000000, 3F800000.

Source files
------------

// File: rtl/ray_gen_if.sv
// Ray output stream: three packed float32 direction components plus the pixel tag.
interface ray_gen_if #(
  parameter int SIZE = 32
);
  logic [2:0][SIZE-1:0] ray_axis_tdata;
  logic                 ray_axis_tvalid;
  logic                 ray_axis_tready;
  logic [10:0]          hcount_axis_tdata;
  logic [9:0]           vcount_axis_tdata;

  modport master (
    output ray_axis_tdata, ray_axis_tvalid, hcount_axis_tdata, vcount_axis_tdata,
    input  ray_axis_tready
  );

  modport slave (
    input  ray_axis_tdata, ray_axis_tvalid, hcount_axis_tdata, vcount_axis_tdata,
    output ray_axis_tready
  );
endinterface

// File: rtl/ray_gen.sv
// Primary-ray generator: raster-scans the render window and streams one float32
// direction (dx, dy, dz) per pixel through a single output register stage.
module ray_gen #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 180,
  parameter int H_CENTER = 160,
  parameter int V_CENTER = 90,
  parameter int FOCAL    = 200,
  parameter int SIZE     = 32
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       start,
  input  logic [1:0] select_objs_in,
  ray_gen_if.master  ray_axis,
  output logic [1:0] select_objs,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [10:0]        H_LAST = 11'(H_ACTIVE - 1);
  localparam logic [9:0]         V_LAST = 10'(V_ACTIVE - 1);
  localparam logic signed [12:0] HC     = 13'(H_CENTER);
  localparam logic signed [12:0] VC     = 13'(V_CENTER);
  localparam logic signed [12:0] DZ     = 13'(-FOCAL);

  state_t               state_q, state_d;
  logic [10:0]          hcnt_q, hcnt_d;
  logic [9:0]           vcnt_q, vcnt_d;
  logic                 more_q, more_d;
  logic [2:0][SIZE-1:0] tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d;
  logic [10:0]          hout_q, hout_d;
  logic [9:0]           vout_q, vout_d;
  logic [1:0]           sel_q, sel_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic signed [12:0]   dx_s, dy_s;
  logic                 hs, load;

  // Exact int->float32: every magnitude here fits in 13 bits, so no rounding is needed.
  function automatic logic [31:0] int_to_f32(input logic signed [12:0] v);
    logic [12:0] mag;
    logic [3:0]  msb;
    logic [23:0] norm;
    logic [31:0] res;
    mag = v[12] ? 13'(~v + 13'sd1) : 13'(v);
    msb = 4'd0;
    for (int i = 0; i < 13; i++) begin
      if (mag[i]) msb = 4'(i);
    end
    norm = 24'(mag) << (5'd23 - 5'(msb));
    if (mag == 13'd0) res = 32'h0000_0000;
    else              res = {v[12], 8'(8'd127 + 8'(msb)), norm[22:0]};
    return res;
  endfunction

  assign dx_s = $signed({2'b00, hcnt_q}) - HC;
  assign dy_s = VC - $signed({3'b000, vcnt_q});
  assign hs   = tvalid_q & ray_axis.ray_axis_tready;
  assign load = (state_q == RUN) && more_q && (!tvalid_q || ray_axis.ray_axis_tready);

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    more_d   = more_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    hout_d   = hout_q;
    vout_d   = vout_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          sel_d   = select_objs_in;
          hcnt_d  = 11'd0;
          vcnt_d  = 10'd0;
          more_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (load) begin
          tdata_d  = {int_to_f32(dx_s), int_to_f32(dy_s), int_to_f32(DZ)};
          tvalid_d = 1'b1;
          hout_d   = hcnt_q;
          vout_d   = vcnt_q;
          if (hcnt_q == H_LAST) begin
            hcnt_d = 11'd0;
            if (vcnt_q == V_LAST) more_d = 1'b0;
            else                  vcnt_d = vcnt_q + 10'd1;
          end else begin
            hcnt_d = hcnt_q + 11'd1;
          end
        end else if (hs) begin
          tvalid_d = 1'b0;
        end
        // more_q low means the beat on the bus is the final pixel of the frame.
        if (hs && !more_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      more_q   <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      hout_q   <= '0;
      vout_q   <= '0;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      more_q   <= more_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      hout_q   <= hout_d;
      vout_q   <= vout_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ray_axis.ray_axis_tdata    = tdata_q;
  assign ray_axis.ray_axis_tvalid   = tvalid_q;
  assign ray_axis.hcount_axis_tdata = hout_q;
  assign ray_axis.vcount_axis_tdata = vout_q;
  assign select_objs                = sel_q;
  assign busy                       = busy_q;
  assign frame_done                 = done_q;

endmodule

// File: tb/tb_ray_gen.sv
// Bench for ray_gen: full-size frame, a mid-size instance under random backpressure
// and abort, and a 3x2 instance for exact small-frame sequencing.
module tb_ray_gen;

  localparam int AH = 320, AV = 180;
  localparam int BH = 16, BV = 12, BHC = 5, BVC = 7, BF = 37;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic rst_a, rst_b, rst_c;
  logic start_a, start_b, start_c;
  logic [1:0] seli_a, seli_b, seli_c, selo_a, selo_b, selo_c;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c;
  int total, bad;

  ray_gen_if #(.SIZE(32)) ifa ();
  ray_gen_if #(.SIZE(32)) ifb ();
  ray_gen_if #(.SIZE(32)) ifc ();

  ray_gen u_a (
    .aclk(aclk), .aresetn(rst_a), .start(start_a), .select_objs_in(seli_a),
    .ray_axis(ifa), .select_objs(selo_a), .busy(busy_a), .frame_done(done_a));

  ray_gen #(.H_ACTIVE(BH), .V_ACTIVE(BV), .H_CENTER(BHC), .V_CENTER(BVC), .FOCAL(BF)) u_b (
    .aclk(aclk), .aresetn(rst_b), .start(start_b), .select_objs_in(seli_b),
    .ray_axis(ifb), .select_objs(selo_b), .busy(busy_b), .frame_done(done_b));

  ray_gen #(.H_ACTIVE(3), .V_ACTIVE(2), .H_CENTER(1), .V_CENTER(1), .FOCAL(1)) u_c (
    .aclk(aclk), .aresetn(rst_c), .start(start_c), .select_objs_in(seli_c),
    .ray_axis(ifc), .select_objs(selo_c), .busy(busy_c), .frame_done(done_c));

  // Reference: go through the double-precision encoding and re-pack as single.
  function automatic logic [31:0] to_f32(input int x);
    logic [63:0] b;
    logic [10:0] e;
    if (x == 0) return 32'h0;
    b = $realtobits(real'(x));
    e = b[62:52];
    return {b[63], 8'(e - 11'd896), b[51:29]};
  endfunction

  function automatic logic [95:0] ray_of(input int h, input int v, input int hc, input int vc, input int f);
    return {to_f32(h - hc), to_f32(vc - v), to_f32(-f)};
  endfunction

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    total++; if (ifa.ray_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", ifa.ray_axis_tvalid); end
    total++; if (ifa.ray_axis_tdata !== 96'h0) begin bad++; $display("FAIL reset_tdata got=%h want=0", ifa.ray_axis_tdata); end
    total++; if (ifa.hcount_axis_tdata !== 11'd0 || ifa.vcount_axis_tdata !== 10'd0) begin bad++; $display("FAIL reset_hv got=%0d,%0d want=0,0", ifa.hcount_axis_tdata, ifa.vcount_axis_tdata); end
    total++; if (selo_a !== 2'b00) begin bad++; $display("FAIL reset_sel got=%b want=00", selo_a); end
    total++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%b%b want=00", busy_a, done_a); end
    total++; if (ifb.ray_axis_tvalid !== 1'b0 || ifc.ray_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid_bc got=%b%b want=00", ifb.ray_axis_tvalid, ifc.ray_axis_tvalid); end
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
  endtask

  task automatic test_continuous();
    int n, cyc, gaps, mism, dones;
    logic [95:0] d, first_d, mid_d, last_d;
    n = 0; cyc = 0; gaps = 0; mism = 0; dones = 0;
    first_d = '0; mid_d = '1; last_d = '0;
    ifa.ray_axis_tready = 1'b1; seli_a = 2'b10;
    @(posedge aclk); #1 start_a = 1'b1;
    @(posedge aclk); #1 start_a = 1'b0; seli_a = 2'b00;
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL cont_busy got=%b want=1", busy_a); end
    total++; if (ifa.ray_axis_tvalid !== 1'b0) begin bad++; $display("FAIL cont_latency_early got=%b want=0", ifa.ray_axis_tvalid); end
    while (n < AH * AV && cyc < AH * AV + 100) begin
      @(posedge aclk); #1; cyc++;
      if (done_a) dones++;
      if (!ifa.ray_axis_tvalid) gaps++;
      else begin
        d = ifa.ray_axis_tdata;
        if (ifa.hcount_axis_tdata !== 11'(n % AH) || ifa.vcount_axis_tdata !== 10'(n / AH)
            || d !== ray_of(n % AH, n / AH, 160, 90, 200)) mism++;
        if (n == 0) first_d = d;
        if (n == 90 * AH + 160) mid_d = d;
        if (n == AH * AV - 1) last_d = d;
        n++;
      end
    end
    total++; if (n !== AH * AV) begin bad++; $display("FAIL cont_count got=%0d want=%0d", n, AH * AV); end
    total++; if (gaps !== 0) begin bad++; $display("FAIL cont_gaps got=%0d want=0", gaps); end
    total++; if (mism !== 0) begin bad++; $display("FAIL cont_beats mismatching=%0d want=0", mism); end
    total++; if (first_d !== 96'hC3200000_42B40000_C3480000) begin bad++; $display("FAIL cont_first got=%h want=C320000042B40000C3480000", first_d); end
    total++; if (mid_d[95:32] !== 64'h0) begin bad++; $display("FAIL cont_axis_zero got=%h want=0", mid_d[95:32]); end
    total++; if (last_d !== 96'h431F0000_C2B20000_C3480000) begin bad++; $display("FAIL cont_last got=%h want=431F0000C2B20000C3480000", last_d); end
    total++; if (selo_a !== 2'b10) begin bad++; $display("FAIL cont_sel got=%b want=10", selo_a); end
    total++; if (dones !== 0) begin bad++; $display("FAIL cont_early_done got=%0d want=0", dones); end
    @(posedge aclk); #1;
    total++; if (done_a !== 1'b1 || busy_a !== 1'b0 || ifa.ray_axis_tvalid !== 1'b0) begin bad++; $display("FAIL cont_end done/busy/tvalid got=%b%b%b want=100", done_a, busy_a, ifa.ray_axis_tvalid); end
    @(posedge aclk); #1;
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL cont_done_pulse got=%b want=0", done_a); end
  endtask

  task automatic test_backpressure();
    int n, cyc, mism, stallerr, selerr;
    bit fin, stalled, poked, r;
    logic [95:0] pd;
    logic [10:0] ph;
    logic [9:0] pv;
    n = 0; cyc = 0; mism = 0; stallerr = 0; selerr = 0;
    fin = 0; stalled = 0; poked = 0; pd = '0; ph = '0; pv = '0;
    ifb.ray_axis_tready = 1'b0; seli_b = 2'b11;
    @(posedge aclk); #1 start_b = 1'b1;
    @(posedge aclk); #1 start_b = 1'b0; seli_b = 2'b00;
    while (!fin && cyc < 3000) begin
      @(posedge aclk); #1; cyc++;
      start_b = 1'b0;
      if (selo_b !== 2'b11) selerr++;
      if (done_b) fin = 1;
      else begin
        if (stalled && (!ifb.ray_axis_tvalid || ifb.ray_axis_tdata !== pd
            || ifb.hcount_axis_tdata !== ph || ifb.vcount_axis_tdata !== pv)) stallerr++;
        if (ifb.ray_axis_tvalid && (ifb.hcount_axis_tdata !== 11'(n % BH) || ifb.vcount_axis_tdata !== 10'(n / BH)
            || ifb.ray_axis_tdata !== ray_of(n % BH, n / BH, BHC, BVC, BF))) mism++;
        r = 1'($urandom_range(0, 1));
        ifb.ray_axis_tready = r;
        stalled = ifb.ray_axis_tvalid && !r;
        pd = ifb.ray_axis_tdata; ph = ifb.hcount_axis_tdata; pv = ifb.vcount_axis_tdata;
        if (ifb.ray_axis_tvalid && r) n++;
        if (n == 40 && !poked) begin start_b = 1'b1; seli_b = 2'b01; poked = 1; end
      end
    end
    total++; if (fin !== 1'b1) begin bad++; $display("FAIL bp_done_timeout got=%b want=1", fin); end
    total++; if (n !== BH * BV) begin bad++; $display("FAIL bp_count got=%0d want=%0d", n, BH * BV); end
    total++; if (mism !== 0) begin bad++; $display("FAIL bp_beats mismatching=%0d want=0", mism); end
    total++; if (stallerr !== 0) begin bad++; $display("FAIL bp_stable unstable=%0d want=0", stallerr); end
    total++; if (selerr !== 0) begin bad++; $display("FAIL bp_sel_held bad_cycles=%0d want=0", selerr); end
    ifb.ray_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    total++; if (busy_b !== 1'b0 || ifb.ray_axis_tvalid !== 1'b0) begin bad++; $display("FAIL bp_start_ignored busy/tvalid got=%b%b want=00", busy_b, ifb.ray_axis_tvalid); end
  endtask

  task automatic test_abort();
    int n, cyc, mism, early;
    bit fin;
    // Full-size instance: abort around beat 1000, then confirm the scan restarts at (0,0).
    n = 0; cyc = 0; mism = 0; early = 0;
    ifa.ray_axis_tready = 1'b1; seli_a = 2'b01;
    @(posedge aclk); #1 start_a = 1'b1;
    @(posedge aclk); #1 start_a = 1'b0;
    while (n < 1000 && cyc < 1200) begin
      @(posedge aclk); #1; cyc++;
      if (ifa.ray_axis_tvalid) n++;
    end
    total++; if (ifa.ray_axis_tvalid !== 1'b1) begin bad++; $display("FAIL abort_a_pre tvalid got=%b want=1", ifa.ray_axis_tvalid); end
    #3 rst_a = 1'b0;
    #1;
    total++; if (ifa.ray_axis_tvalid !== 1'b0 || busy_a !== 1'b0) begin bad++; $display("FAIL abort_a_async tvalid/busy got=%b%b want=00", ifa.ray_axis_tvalid, busy_a); end
    total++; if (ifa.hcount_axis_tdata !== 11'd0 || ifa.ray_axis_tdata !== 96'h0) begin bad++; $display("FAIL abort_a_clear h=%0d tdata=%h want 0", ifa.hcount_axis_tdata, ifa.ray_axis_tdata); end
    #2 rst_a = 1'b1;
    @(posedge aclk); #1 start_a = 1'b1;
    @(posedge aclk); #1 start_a = 1'b0;
    n = 0; cyc = 0;
    while (n < 50 && cyc < 100) begin
      @(posedge aclk); #1; cyc++;
      if (done_a) early++;
      if (ifa.ray_axis_tvalid) begin
        if (ifa.hcount_axis_tdata !== 11'(n % AH) || ifa.vcount_axis_tdata !== 10'(n / AH)
            || ifa.ray_axis_tdata !== ray_of(n % AH, n / AH, 160, 90, 200)) mism++;
        n++;
      end
    end
    total++; if (mism !== 0 || n !== 50) begin bad++; $display("FAIL abort_a_restart mismatching=%0d beats=%0d want 0,50", mism, n); end
    total++; if (early !== 0) begin bad++; $display("FAIL abort_a_done got=%0d want=0", early); end
    rst_a = 1'b0;

    // Mid-size instance: abort, then the next frame must finish with exactly one frame_done.
    n = 0; cyc = 0; mism = 0; early = 0; fin = 0;
    ifb.ray_axis_tready = 1'b1;
    @(posedge aclk); #1 start_b = 1'b1;
    @(posedge aclk); #1 start_b = 1'b0;
    while (n < 100 && cyc < 200) begin
      @(posedge aclk); #1; cyc++;
      if (ifb.ray_axis_tvalid) n++;
    end
    #3 rst_b = 1'b0;
    #1;
    total++; if (ifb.ray_axis_tvalid !== 1'b0 || busy_b !== 1'b0) begin bad++; $display("FAIL abort_b_async tvalid/busy got=%b%b want=00", ifb.ray_axis_tvalid, busy_b); end
    #2 rst_b = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    total++; if (done_b !== 1'b0 || busy_b !== 1'b0) begin bad++; $display("FAIL abort_b_idle done/busy got=%b%b want=00", done_b, busy_b); end
    start_b = 1'b1;
    @(posedge aclk); #1 start_b = 1'b0;
    n = 0; cyc = 0;
    while (!fin && cyc < 500) begin
      @(posedge aclk); #1; cyc++;
      if (done_b) begin fin = 1; if (n != BH * BV) early++; end
      else if (ifb.ray_axis_tvalid) begin
        if (ifb.hcount_axis_tdata !== 11'(n % BH) || ifb.vcount_axis_tdata !== 10'(n / BH)
            || ifb.ray_axis_tdata !== ray_of(n % BH, n / BH, BHC, BVC, BF)) mism++;
        n++;
      end
    end
    total++; if (fin !== 1'b1 || early !== 0) begin bad++; $display("FAIL abort_b_frame_done seen=%b misplaced=%0d want 1,0", fin, early); end
    total++; if (n !== BH * BV || mism !== 0) begin bad++; $display("FAIL abort_b_frame beats=%0d mismatching=%0d want %0d,0", n, mism, BH * BV); end
  endtask

  task automatic test_small();
    int n, cyc;
    int eh[6];
    int ev[6];
    logic [31:0] edx[6];
    eh = '{0, 1, 2, 0, 1, 2};
    ev = '{0, 0, 0, 1, 1, 1};
    edx = '{32'hBF800000, 32'h00000000, 32'h3F800000, 32'hBF800000, 32'h00000000, 32'h3F800000};
    n = 0; cyc = 0;
    ifc.ray_axis_tready = 1'b1; seli_c = 2'b11;
    @(posedge aclk); #1 start_c = 1'b1;
    @(posedge aclk); #1 start_c = 1'b0;
    while (n < 6 && cyc < 20) begin
      @(posedge aclk); #1; cyc++;
      if (ifc.ray_axis_tvalid) begin
        total++; if (ifc.hcount_axis_tdata !== 11'(eh[n]) || ifc.vcount_axis_tdata !== 10'(ev[n])) begin bad++; $display("FAIL small_hv beat%0d got=%0d,%0d want=%0d,%0d", n, ifc.hcount_axis_tdata, ifc.vcount_axis_tdata, eh[n], ev[n]); end
        total++; if (ifc.ray_axis_tdata[2] !== edx[n]) begin bad++; $display("FAIL small_dx beat%0d got=%h want=%h", n, ifc.ray_axis_tdata[2], edx[n]); end
        total++; if (ifc.ray_axis_tdata !== ray_of(eh[n], ev[n], 1, 1, 1)) begin bad++; $display("FAIL small_tdata beat%0d got=%h want=%h", n, ifc.ray_axis_tdata, ray_of(eh[n], ev[n], 1, 1, 1)); end
        if (n == 5) start_c = 1'b1;
        n++;
      end
    end
    total++; if (n !== 6) begin bad++; $display("FAIL small_count got=%0d want=6", n); end
    @(posedge aclk); #1 start_c = 1'b0;
    total++; if (done_c !== 1'b1 || busy_c !== 1'b0) begin bad++; $display("FAIL small_done done/busy got=%b%b want=10", done_c, busy_c); end
    repeat (2) @(posedge aclk);
    #1;
    total++; if (busy_c !== 1'b0 || ifc.ray_axis_tvalid !== 1'b0) begin bad++; $display("FAIL small_start_on_done busy/tvalid got=%b%b want=00", busy_c, ifc.ray_axis_tvalid); end
    start_c = 1'b1;
    @(posedge aclk); #1 start_c = 1'b0;
    total++; if (busy_c !== 1'b1) begin bad++; $display("FAIL small_restart busy got=%b want=1", busy_c); end
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    seli_a = 2'b00; seli_b = 2'b00; seli_c = 2'b00;
    ifa.ray_axis_tready = 1'b0; ifb.ray_axis_tready = 1'b0; ifc.ray_axis_tready = 1'b0;
    test_reset();
    test_continuous();
    test_backpressure();
    test_abort();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
